// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
//   Shared constants for the parametrised serial-pattern detector.
//   DEFAULT_PATTERN : legacy "1100" pattern, first received bit in the MSB
//   OVERLAP_*       : values for the detector's OVERLAP parameter
//   STATE_W         : width of the matched-prefix state (covers 0..16)
// ---------------------------------------------------------------------------
package seq_det_pkg;

   localparam int         STATE_W         = 5;
   localparam logic [3:0] DEFAULT_PATTERN = 4'b1100;

   // OVERLAP_RESTART: after a full match the search starts from an empty history.
   // OVERLAP_ALLOW  : the tail of a match may begin the next one.
   localparam bit OVERLAP_RESTART = 1'b0;
   localparam bit OVERLAP_ALLOW   = 1'b1;

endpackage

// File: rtl/seq_detector_param_prefix_match.sv
// ---------------------------------------------------------------------------
// prefix_match
//   Combinational longest-prefix finder. Returns the largest k (1..limit) such
//   that the newest k bits of w equal the first k bits of pat; 0 if none.
//   Ports:
//     w     in  PAT_LEN  window of recent bits, newest bit in w[0]
//     pat   in  PAT_LEN  pattern, first bit to be received in pat[PAT_LEN-1]
//     limit in  STATE_W  upper bound on k (number of valid bits in w)
//     k     out STATE_W  longest matching prefix length
// ---------------------------------------------------------------------------
module prefix_match
   import seq_det_pkg::*;
#(
   parameter int PAT_LEN = 4
)(
   input  logic [PAT_LEN-1:0] w,
   input  logic [PAT_LEN-1:0] pat,
   input  logic [STATE_W-1:0] limit,
   output logic [STATE_W-1:0] k
);

   // cand[j]: a prefix of length j matches and only uses valid history bits
   logic [PAT_LEN:1] cand;

   generate
      for (genvar gi = 1; gi <= PAT_LEN; gi++) begin : g_len
         assign cand[gi] = (w[gi-1:0] == pat[PAT_LEN-1 -: gi]) &&
                           (STATE_W'(gi) <= limit);
      end
   endgenerate

   // Ascending scan so the longest candidate wins.
   always_comb begin
      k = '0;
      for (int j = 1; j <= PAT_LEN; j++) begin
         if (cand[j]) k = STATE_W'(j);
      end
   end

endmodule

// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//   Parametrised Moore serial-pattern detector with runtime-loadable pattern
//   and a saturating match counter.
//   Ports:
//     clk        in   1        rising-edge clock
//     rst        in   1        asynchronous active-high reset
//     en         in   1        sample din this cycle; 0 holds all state
//     din        in   1        serial data bit
//     pat_we     in   1        load pat_in as active pattern (priority over en)
//     pat_in     in   PAT_LEN  new pattern, first bit received in MSB
//     cnt_clr    in   1        synchronous clear of match_cnt
//     match      out  1        high while the full pattern has been matched
//     state_o    out  5        matched-prefix length 0..PAT_LEN
//     match_cnt  out  CNT_W    saturating match count
//     cnt_sat    out  1        match_cnt is all ones
// ---------------------------------------------------------------------------
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEFAULT_PATTERN),
   parameter bit                 OVERLAP = OVERLAP_ALLOW,
   parameter int                 CNT_W   = 8
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               din,
   input  logic               pat_we,
   input  logic [PAT_LEN-1:0] pat_in,
   input  logic               cnt_clr,
   output logic               match,
   output logic [STATE_W-1:0] state_o,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cnt_sat
);

   localparam logic [STATE_W-1:0] FULL = STATE_W'(PAT_LEN);

   logic [STATE_W-1:0] state_reg;
   logic [STATE_W-1:0] fill_reg;
   logic [PAT_LEN-2:0] hist_reg;
   logic [PAT_LEN-1:0] pat_reg;
   logic               match_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic               sat_reg;

   logic [PAT_LEN-1:0] w;
   logic [STATE_W-1:0] eff_fill;
   logic [STATE_W-1:0] limit;
   logic [STATE_W-1:0] k_next;
   logic               hit;
   logic [CNT_W-1:0]   cnt_next;

   // Without overlap, a completed match forgets all history so only the
   // incoming bit can start the next search.
   always_comb begin
      w        = {hist_reg, din};
      eff_fill = (OVERLAP == OVERLAP_RESTART && state_reg == FULL) ? '0 : fill_reg;
      limit    = (eff_fill >= FULL) ? FULL : eff_fill + STATE_W'(1);
   end

   prefix_match #(
      .PAT_LEN (PAT_LEN)
   ) u_prefix (
      .w     (w),
      .pat   (pat_reg),
      .limit (limit),
      .k     (k_next)
   );

   assign hit = en && !pat_we && (k_next == FULL);

   // Clear beats a same-cycle increment; the count sticks at all ones.
   always_comb begin
      cnt_next = cnt_reg;
      if (cnt_clr)
         cnt_next = '0;
      else if (hit && cnt_reg != '1)
         cnt_next = cnt_reg + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= '0;
         fill_reg  <= '0;
         hist_reg  <= '0;
         pat_reg   <= PATTERN;
         match_reg <= 1'b0;
         cnt_reg   <= '0;
         sat_reg   <= 1'b0;
      end else begin
         if (pat_we) begin
            // New pattern: restart the search, din is dropped.
            pat_reg   <= pat_in;
            state_reg <= '0;
            fill_reg  <= '0;
            match_reg <= 1'b0;
         end else if (en) begin
            state_reg <= k_next;
            fill_reg  <= limit;          // min(valid bits + 1, PAT_LEN)
            hist_reg  <= w[PAT_LEN-2:0];
            match_reg <= (k_next == FULL);
         end
         cnt_reg <= cnt_next;
         sat_reg <= &cnt_next;
      end
   end

   assign match     = match_reg;
   assign state_o   = state_reg;
   assign match_cnt = cnt_reg;
   assign cnt_sat   = sat_reg;

endmodule
